// File: rtl/pixel_stream_fifo.sv
// -----------------------------------------------------------------------------
// pixel_stream_fifo
//
// Buffers a valid/ready RGB pixel stream with a start-of-frame marker and
// serves it to the LCD timing generator through a first-word-fall-through
// request interface. Stream frames are locked to display frames: the head
// sof entry is only released at display coordinate (0,0), and underflow or
// frame-length mismatch drops the lock and resynchronises.
//
// Ports
//   pclk, rst          pixel clock, asynchronous active-high reset
//   s_data/s_sof       stream pixel and its start-of-frame flag
//   s_valid/s_ready    stream handshake; s_ready = !full
//   pixel_request      consumer samples pixel_data in this cycle
//   pixel_x/pixel_y    display coordinate of the requested pixel
//   pixel_data         combinational pixel (FILL_COLOR unless popping)
//   locked             high while frames are aligned (RUN)
//   fill_level         entries held, 0..DEPTH
//   underflow_cnt      saturating count of empty requests in RUN
//   resync_cnt         saturating count of frame misalignments
// -----------------------------------------------------------------------------
module pixel_stream_fifo #(
    parameter int unsigned        DATA_W     = 24,
    parameter int unsigned        DEPTH      = 1024,
    parameter int unsigned        ADDR_W     = 10,
    parameter logic [DATA_W-1:0]  FILL_COLOR = 24'h000000,
    parameter int unsigned        CNT_W      = 16
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              pixel_request,
    input  logic [10:0]       pixel_x,
    input  logic [10:0]       pixel_y,
    output logic [DATA_W-1:0] pixel_data,
    output logic              locked,
    output logic [ADDR_W:0]   fill_level,
    output logic [CNT_W-1:0]  underflow_cnt,
    output logic [CNT_W-1:0]  resync_cnt
);

    localparam logic [ADDR_W:0] FullLevel = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StSeek, StAlign, StRun} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [DATA_W:0]     r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_fill;
    logic [CNT_W-1:0]    r_underflow_cnt;
    logic [CNT_W-1:0]    r_resync_cnt;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_first;
    logic [DATA_W:0]     w_head;
    logic                w_underflow_inc;
    logic                w_resync_inc;

    // Flags derive from registered fill only, so s_ready never depends on s_valid.
    assign w_full  = (r_fill == FullLevel);
    assign w_empty = (r_fill == '0);
    assign w_push  = s_valid && !w_full;
    assign w_first = (pixel_x == '0) && (pixel_y == '0);
    assign w_head  = r_mem[r_rd_ptr];

    assign s_ready       = !w_full;
    assign locked        = (r_state == StRun);
    assign fill_level    = r_fill;
    assign underflow_cnt = r_underflow_cnt;
    assign resync_cnt    = r_resync_cnt;

    always_comb begin
        w_state_next    = r_state;
        w_pop           = 1'b0;
        pixel_data      = FILL_COLOR;
        w_underflow_inc = 1'b0;
        w_resync_inc    = 1'b0;
        case (r_state)
            StSeek: begin
                // Discard until a frame start reaches the head.
                if (!w_empty) begin
                    if (w_head[DATA_W]) begin
                        w_state_next = StAlign;
                    end else begin
                        w_pop = 1'b1;
                    end
                end
            end
            StAlign: begin
                if (pixel_request && w_first && !w_empty) begin
                    w_pop        = 1'b1;
                    pixel_data   = w_head[DATA_W-1:0];
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (pixel_request) begin
                    if (w_empty) begin
                        w_underflow_inc = 1'b1;
                        w_state_next    = StSeek;
                    end else if (w_first && !w_head[DATA_W]) begin
                        // Stream frame longer than the display frame.
                        w_resync_inc = 1'b1;
                        w_state_next = StSeek;
                    end else if (!w_first && w_head[DATA_W]) begin
                        // Stream frame shorter: keep the sof entry for the next (0,0).
                        w_resync_inc = 1'b1;
                        w_state_next = StAlign;
                    end else begin
                        w_pop      = 1'b1;
                        pixel_data = w_head[DATA_W-1:0];
                    end
                end
            end
            default: w_state_next = StSeek;
        endcase
    end

    // Storage carries no reset; pointers and fill define what is valid.
    always_ff @(posedge pclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_sof, s_data};
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state         <= StSeek;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_fill          <= '0;
            r_underflow_cnt <= '0;
            r_resync_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
            if (w_underflow_inc && (r_underflow_cnt != '1)) begin
                r_underflow_cnt <= r_underflow_cnt + 1'b1;
            end
            if (w_resync_inc && (r_resync_cnt != '1)) begin
                r_resync_cnt <= r_resync_cnt + 1'b1;
            end
        end
    end

endmodule
